// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_queue
// Brief    : In-order writeback FIFO feeding the register-file write port, with
//            PC-latch drain suspension and a per-register pending mask.
//            Optional tail coalescing is enabled by defining WB_COALESCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                     clka,
    input  logic                     reset_n_in,
    input  logic                     wb_valid_in,
    input  logic [ADDR_W-1:0]        wb_rd_in,
    input  logic [DATA_W-1:0]        wb_data_in,
    output logic                     wb_ready_out,
    input  logic                     pc_latch_in,
    output logic                     we_reg_out,
    output logic [ADDR_W-1:0]        rd_out,
    output logic [DATA_W-1:0]        data_out,
    output logic [(2**ADDR_W)-1:0]   pending_out,
    output logic [$clog2(DEPTH):0]   count_out,
    output logic                     overflow_out
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [ADDR_W-1:0]    r_mem_rd   [DEPTH];
    logic [DATA_W-1:0]    r_mem_data [DEPTH];
    logic [c_PTR_W-1:0]   r_head;
    logic [c_PTR_W-1:0]   r_tail;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_count_next;

    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_coalesce;
    logic [c_PTR_W-1:0]   w_off;
    logic [(2**ADDR_W)-1:0] w_pending;

    assign w_full = (r_count == c_CNT_W'(DEPTH));
    // The FSM tracks occupancy, so "not EMPTY" is the same as count > 0.
    assign w_pop  = (r_state != ST_EMPTY) && !pc_latch_in;

`ifdef WB_COALESCE_EN
    logic [c_PTR_W-1:0] w_tail_last;
    assign w_tail_last = r_tail - c_PTR_W'(1);
    // With a single entry that is popping this edge, the tail is leaving: allocate instead.
    assign w_coalesce  = wb_valid_in && (r_count != '0) &&
                         (r_mem_rd[w_tail_last] == wb_rd_in) &&
                         !(w_pop && (r_count == c_CNT_W'(1)));
`else
    assign w_coalesce  = 1'b0;
`endif

    assign wb_ready_out = !w_full || w_coalesce;
    assign w_push       = wb_valid_in && wb_ready_out && !w_coalesce;
    assign w_count_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    assign count_out    = r_count;
    assign pending_out  = w_pending;

    always_comb begin
        w_state_next = r_state;
        if (w_count_next == '0)
            w_state_next = ST_EMPTY;
        else if (pc_latch_in)
            w_state_next = ST_STALL;
        else
            w_state_next = ST_ACTIVE;
    end

    always_comb begin
        w_pending = '0;
        w_off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_off = c_PTR_W'(i) - r_head;
            if (c_CNT_W'(w_off) < r_count)
                w_pending[r_mem_rd[i]] = 1'b1;
        end
        if (we_reg_out)
            w_pending[rd_out] = 1'b1;
    end

    // Storage carries no reset; validity is defined solely by head/count.
    always_ff @(posedge clka) begin
        if (w_push) begin
            r_mem_rd[r_tail]   <= wb_rd_in;
            r_mem_data[r_tail] <= wb_data_in;
        end
`ifdef WB_COALESCE_EN
        if (w_coalesce)
            r_mem_data[w_tail_last] <= wb_data_in;
`endif
    end

    always_ff @(posedge clka or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state      <= ST_EMPTY;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            we_reg_out   <= 1'b0;
            rd_out       <= '0;
            data_out     <= '0;
            overflow_out <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            we_reg_out <= w_pop;
            if (w_pop) begin
                rd_out   <= r_mem_rd[r_head];
                data_out <= r_mem_data[r_head];
                r_head   <= r_head + c_PTR_W'(1);
            end
            if (w_push)
                r_tail <= r_tail + c_PTR_W'(1);
            if (wb_valid_in && !wb_ready_out)
                overflow_out <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_queue
// Brief    : Directed self-checking bench for regfile_wb_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_queue;

    logic       clka;
    logic       reset_n_in;
    logic       wb_valid_in;
    logic [2:0] wb_rd_in;
    logic [7:0] wb_data_in;
    logic       wb_ready_out;
    logic       pc_latch_in;
    logic       we_reg_out;
    logic [2:0] rd_out;
    logic [7:0] data_out;
    logic [7:0] pending_out;
    logic [2:0] count_out;
    logic       overflow_out;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wb_queue #(.DEPTH(4), .DATA_W(8), .ADDR_W(3)) dut (
        .clka         (clka),
        .reset_n_in   (reset_n_in),
        .wb_valid_in  (wb_valid_in),
        .wb_rd_in     (wb_rd_in),
        .wb_data_in   (wb_data_in),
        .wb_ready_out (wb_ready_out),
        .pc_latch_in  (pc_latch_in),
        .we_reg_out   (we_reg_out),
        .rd_out       (rd_out),
        .data_out     (data_out),
        .pending_out  (pending_out),
        .count_out    (count_out),
        .overflow_out (overflow_out)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic push_stalled(input logic [2:0] rd, input logic [7:0] d);
        wb_valid_in = 1'b1; wb_rd_in = rd; wb_data_in = d;
        step();
        wb_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_in = 1'b0;
        step(); step();
        n_cmp++; if (we_reg_out !== 1'b0) begin n_bad++; $display("FAIL rst_we got %0b want 0", we_reg_out); end
        n_cmp++; if (count_out !== 3'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", count_out); end
        n_cmp++; if (pending_out !== 8'h00) begin n_bad++; $display("FAIL rst_pending got %h want 00", pending_out); end
        n_cmp++; if (wb_ready_out !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %0b want 1", wb_ready_out); end
        n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got %0b want 0", overflow_out); end
        n_cmp++; if ({rd_out, data_out} !== 11'h0) begin n_bad++; $display("FAIL rst_rd_data got %0d/%h want 0/00", rd_out, data_out); end
        reset_n_in = 1'b1;
        repeat (5) step();
        n_cmp++; if (we_reg_out !== 1'b0) begin n_bad++; $display("FAIL idle_we got %0b want 0", we_reg_out); end
        n_cmp++; if (count_out !== 3'd0) begin n_bad++; $display("FAIL idle_count got %0d want 0", count_out); end
        n_cmp++; if (pending_out !== 8'h00) begin n_bad++; $display("FAIL idle_pending got %h want 00", pending_out); end
        n_cmp++; if (wb_ready_out !== 1'b1) begin n_bad++; $display("FAIL idle_ready got %0b want 1", wb_ready_out); end
    endtask

    task automatic test_single();
        wb_valid_in = 1'b1; wb_rd_in = 3'd3; wb_data_in = 8'hA5;
        step();
        wb_valid_in = 1'b0;
        n_cmp++; if (we_reg_out !== 1'b0) begin n_bad++; $display("FAIL single_no_bypass got %0b want 0", we_reg_out); end
        n_cmp++; if (pending_out !== 8'h08) begin n_bad++; $display("FAIL single_pend_n got %h want 08", pending_out); end
        n_cmp++; if (count_out !== 3'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", count_out); end
        step();
        n_cmp++; if (we_reg_out !== 1'b1) begin n_bad++; $display("FAIL single_we got %0b want 1", we_reg_out); end
        n_cmp++; if (rd_out !== 3'd3) begin n_bad++; $display("FAIL single_rd got %0d want 3", rd_out); end
        n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", data_out); end
        n_cmp++; if (pending_out !== 8'h08) begin n_bad++; $display("FAIL single_pend_n1 got %h want 08", pending_out); end
        step();
        n_cmp++; if (we_reg_out !== 1'b0) begin n_bad++; $display("FAIL single_we_off got %0b want 0", we_reg_out); end
        n_cmp++; if (pending_out !== 8'h00) begin n_bad++; $display("FAIL single_pend_clr got %h want 00", pending_out); end
        n_cmp++; if (data_out !== 8'hA5) begin n_bad++; $display("FAIL single_hold got %h want a5", data_out); end
    endtask

    task automatic test_fill_overflow();
        pc_latch_in = 1'b1;
        for (int i = 0; i < 4; i++) push_stalled(3'(i), 8'h10 + 8'(i));
        n_cmp++; if (count_out !== 3'd4) begin n_bad++; $display("FAIL fill_count got %0d want 4", count_out); end
        n_cmp++; if (wb_ready_out !== 1'b0) begin n_bad++; $display("FAIL fill_ready got %0b want 0", wb_ready_out); end
        n_cmp++; if (pending_out !== 8'h0F) begin n_bad++; $display("FAIL fill_pending got %h want 0f", pending_out); end
        n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL fill_ovf_early got %0b want 0", overflow_out); end
        n_cmp++; if (we_reg_out !== 1'b0) begin n_bad++; $display("FAIL fill_we_stalled got %0b want 0", we_reg_out); end
        push_stalled(3'd4, 8'h14);
        n_cmp++; if (overflow_out !== 1'b1) begin n_bad++; $display("FAIL ovf_set got %0b want 1", overflow_out); end
        n_cmp++; if (count_out !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", count_out); end
        n_cmp++; if (pending_out !== 8'h0F) begin n_bad++; $display("FAIL ovf_pending got %h want 0f", pending_out); end
        // First drain edge also offers a write while full: it must be dropped.
        pc_latch_in = 1'b0;
        wb_valid_in = 1'b1; wb_rd_in = 3'd7; wb_data_in = 8'h77;
        for (int i = 0; i < 4; i++) begin
            step();
            wb_valid_in = 1'b0;
            n_cmp++; if (we_reg_out !== 1'b1) begin n_bad++; $display("FAIL drain%0d_we got %0b want 1", i, we_reg_out); end
            n_cmp++; if (data_out !== 8'h10 + 8'(i)) begin n_bad++; $display("FAIL drain%0d_data got %h want %h", i, data_out, 8'h10 + 8'(i)); end
            n_cmp++; if (rd_out !== 3'(i)) begin n_bad++; $display("FAIL drain%0d_rd got %0d want %0d", i, rd_out, i); end
            n_cmp++; if (count_out !== 3'(3 - i)) begin n_bad++; $display("FAIL drain%0d_count got %0d want %0d", i, count_out, 3 - i); end
        end
        step();
        n_cmp++; if (we_reg_out !== 1'b0) begin n_bad++; $display("FAIL drain_done_we got %0b want 0", we_reg_out); end
        n_cmp++; if (overflow_out !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %0b want 1", overflow_out); end
    endtask

    task automatic test_stall_mid();
        pc_latch_in = 1'b1;
        push_stalled(3'd1, 8'h21);
        push_stalled(3'd2, 8'h22);
        push_stalled(3'd5, 8'h25);
        pc_latch_in = 1'b0;
        step();
        n_cmp++; if ({we_reg_out, rd_out, data_out} !== {1'b1, 3'd1, 8'h21}) begin n_bad++; $display("FAIL stall_first got we=%0b rd=%0d d=%h want 1/1/21", we_reg_out, rd_out, data_out); end
        pc_latch_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (we_reg_out !== 1'b0) begin n_bad++; $display("FAIL stall_we%0d got %0b want 0", i, we_reg_out); end
        end
        n_cmp++; if (count_out !== 3'd2) begin n_bad++; $display("FAIL stall_count got %0d want 2", count_out); end
        n_cmp++; if (pending_out !== 8'h24) begin n_bad++; $display("FAIL stall_pending got %h want 24", pending_out); end
        pc_latch_in = 1'b0;
        step();
        n_cmp++; if ({we_reg_out, rd_out, data_out} !== {1'b1, 3'd2, 8'h22}) begin n_bad++; $display("FAIL stall_second got we=%0b rd=%0d d=%h want 1/2/22", we_reg_out, rd_out, data_out); end
        step();
        n_cmp++; if ({we_reg_out, rd_out, data_out} !== {1'b1, 3'd5, 8'h25}) begin n_bad++; $display("FAIL stall_third got we=%0b rd=%0d d=%h want 1/5/25", we_reg_out, rd_out, data_out); end
        step();
        n_cmp++; if (we_reg_out !== 1'b0) begin n_bad++; $display("FAIL stall_end_we got %0b want 0", we_reg_out); end
    endtask

    task automatic test_back_to_back();
        pc_latch_in = 1'b1;
        push_stalled(3'd0, 8'h30);
        push_stalled(3'd1, 8'h31);
        pc_latch_in = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wb_valid_in = 1'b1; wb_rd_in = 3'(k + 2); wb_data_in = 8'h32 + 8'(k);
            step();
            n_cmp++; if (count_out !== 3'd2) begin n_bad++; $display("FAIL b2b%0d_count got %0d want 2", k, count_out); end
            n_cmp++; if ({we_reg_out, rd_out, data_out} !== {1'b1, 3'(k), 8'h30 + 8'(k)}) begin n_bad++; $display("FAIL b2b%0d_out got we=%0b rd=%0d d=%h want 1/%0d/%h", k, we_reg_out, rd_out, data_out, k, 8'h30 + 8'(k)); end
        end
        wb_valid_in = 1'b0;
        for (int k = 6; k < 8; k++) begin
            step();
            n_cmp++; if ({we_reg_out, rd_out, data_out} !== {1'b1, 3'(k), 8'h30 + 8'(k)}) begin n_bad++; $display("FAIL b2b%0d_out got we=%0b rd=%0d d=%h want 1/%0d/%h", k, we_reg_out, rd_out, data_out, k, 8'h30 + 8'(k)); end
        end
        step();
        n_cmp++; if (count_out !== 3'd0) begin n_bad++; $display("FAIL b2b_empty got %0d want 0", count_out); end
    endtask

    task automatic test_reset_mid();
        pc_latch_in = 1'b1;
        push_stalled(3'd2, 8'h41);
        push_stalled(3'd4, 8'h42);
        push_stalled(3'd6, 8'h43);
        pc_latch_in = 1'b0;
        step();
        n_cmp++; if (we_reg_out !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_we got %0b want 1", we_reg_out); end
        #3;
        reset_n_in = 1'b0;
        #1;
        n_cmp++; if (we_reg_out !== 1'b0) begin n_bad++; $display("FAIL rmid_we got %0b want 0", we_reg_out); end
        n_cmp++; if (count_out !== 3'd0) begin n_bad++; $display("FAIL rmid_count got %0d want 0", count_out); end
        n_cmp++; if (pending_out !== 8'h00) begin n_bad++; $display("FAIL rmid_pending got %h want 00", pending_out); end
        n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL rmid_ovf got %0b want 0", overflow_out); end
        n_cmp++; if ({rd_out, data_out} !== 11'h0) begin n_bad++; $display("FAIL rmid_rd_data got %0d/%h want 0/00", rd_out, data_out); end
        wb_valid_in = 1'b1; wb_rd_in = 3'd6; wb_data_in = 8'h66;
        step();
        wb_valid_in = 1'b0;
        reset_n_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if ({we_reg_out, count_out} !== 4'h0) begin n_bad++; $display("FAIL rmid_post%0d got we=%0b count=%0d want 0/0", i, we_reg_out, count_out); end
        end
    endtask

`ifdef WB_COALESCE_EN
    task automatic test_coalesce();
        pc_latch_in = 1'b1;
        push_stalled(3'd5, 8'h01);
        push_stalled(3'd5, 8'h02);
        n_cmp++; if (count_out !== 3'd1) begin n_bad++; $display("FAIL coal_count got %0d want 1", count_out); end
        pc_latch_in = 1'b0;
        step();
        n_cmp++; if ({we_reg_out, rd_out, data_out} !== {1'b1, 3'd5, 8'h02}) begin n_bad++; $display("FAIL coal_out got we=%0b rd=%0d d=%h want 1/5/02", we_reg_out, rd_out, data_out); end
        step();
        n_cmp++; if ({we_reg_out, count_out} !== 4'h0) begin n_bad++; $display("FAIL coal_end got we=%0b count=%0d want 0/0", we_reg_out, count_out); end
    endtask
`endif

    initial begin
        reset_n_in  = 1'b0;
        wb_valid_in = 1'b0;
        wb_rd_in    = '0;
        wb_data_in  = '0;
        pc_latch_in = 1'b0;
        test_reset();
        test_single();
        test_fill_overflow();
        test_stall_mid();
        test_back_to_back();
        test_reset_mid();
`ifdef WB_COALESCE_EN
        test_coalesce();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side producer for the 8-bit register file.
- Accepts writeback results from the ALU and load paths, buffers them in a small in-order FIFO, and drains one entry per cycle onto the register-file write port (rd, we, data).
- Suspends draining while the PC-latch phase is active, because the register file ignores writes in that phase.
- Exports a per-register pending mask so decode can stall on read-after-write hazards.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- DATA_W, 8, writeback data width.
- ADDR_W, 3, register index width (2**ADDR_W registers).

Ports:
- clka  in  1  system clock; all state updates on rising edge.
- reset_n_in  in  1  asynchronous active-low reset.
- wb_valid_in  in  1  producer presents a write this cycle.
- wb_rd_in  in  ADDR_W  destination register.
- wb_data_in  in  DATA_W  result value.
- wb_ready_out  out  1  queue can accept; equals !full.
- pc_latch_in  in  1  1 = register file is in PC-latch phase; drain suspended.
- we_reg_out  out  1  write strobe to register file.
- rd_out  out  ADDR_W  write address to register file.
- data_out  out  DATA_W  write data to register file.
- pending_out  out  2**ADDR_W  bit r set while any queued or presented write targets r.
- count_out  out  $clog2(DEPTH)+1  FIFO occupancy.
- overflow_out  out  1  sticky; a write was offered while full.

Behaviour:
- Reset, asynchronous, while reset_n_in=0: FIFO empty, count_out=0, we_reg_out=0, rd_out=0, data_out=0, overflow_out=0, state=EMPTY. pending_out=0 and wb_ready_out=1.
- Push: on a clka edge with wb_valid_in=1 and wb_ready_out=1, {wb_rd_in, wb_data_in} is written at the tail.
- Offer while full: a write offered with wb_valid_in=1 and wb_ready_out=0 is dropped and sets overflow_out. It stays set until reset.
- Pop: on a clka edge with count>0 and pc_latch_in=0, the head is moved into rd_out/data_out and we_reg_out=1 for exactly that cycle.
  - On any other edge we_reg_out=0.
  - rd_out/data_out hold their last value when not popping.
- Latency:
  - Push at edge N into an empty queue -> we_reg_out=1 after edge N+1 at the earliest.
  - There is no same-cycle bypass.
- Simultaneous push and pop: allowed when not full; count is unchanged.
- Full with a pop that edge: still no push, because ready is based on the pre-edge full flag.
- Ordering: strictly FIFO. Two writes to the same rd retire in arrival order, so the last write wins in the register file.
- Pointers: head and tail are ADDR of width $clog2(DEPTH) and wrap modulo DEPTH. count is tracked separately, range 0..DEPTH.
- pending_out: combinational OR of one-hot(rd) over valid FIFO entries, plus one-hot(rd_out) while we_reg_out=1.
- FSM (state visible only through outputs):
  - EMPTY: count=0. A push -> ACTIVE.
  - ACTIVE: count>0 and pc_latch_in=0. The pop plus no push that leaves count 0 -> EMPTY. pc_latch_in=1 -> STALL.
  - STALL: count>0 and pc_latch_in=1. No pops; pushes still accepted. pc_latch_in=0 -> ACTIVE.
- Register 0 is written like any other register (no hardwired zero).
- Reset mid-operation: all queued entries are discarded. A write presented on the reset edge is lost, and we_reg_out drops immediately.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: if a push targets the same rd as the current tail entry, and that entry is not being popped on the same edge, the tail data is overwritten in place. count is unchanged; this is accepted even when full, with ready asserted for that case.
- Undefined: every accepted push allocates a new entry; no comparison logic is built.

Test Plan:
- Reset then idle:
  - Stimulus: reset_n_in=0, then 1, with no traffic for 5 cycles.
  - Required: we_reg_out=0, count_out=0, pending_out=8'h00, wb_ready_out=1.
- Single write:
  - Stimulus: push rd=3, data=8'hA5 at edge N with pc_latch_in=0.
  - Required after edge N+1: we_reg_out=1, rd_out=3, data_out=8'hA5 for one cycle. pending_out=8'h08 from edge N through edge N+1, then 8'h00.
- Fill and overflow:
  - Stimulus: hold pc_latch_in=1; push rd=0..3 with data 8'h10..8'h13; then push rd=4.
  - Required: count_out=4, wb_ready_out=0, the rd=4 write is dropped and overflow_out=1.
  - Then release pc_latch_in: drains 8'h10, 8'h11, 8'h12, 8'h13 on 4 consecutive cycles.
- Stall mid-drain:
  - Stimulus: 3 queued entries; pc_latch_in=1 for 2 cycles after the first pop.
  - Required: we_reg_out=0 during the stall; the remaining 2 pop in order afterward.
- Concurrent push and pop:
  - Stimulus: count=2 and a push each cycle for 6 cycles.
  - Required: count_out stays 2, with a continuous we_reg_out=1 stream in arrival order.
- Reset mid-operation:
  - Stimulus: 3 entries queued; reset_n_in pulsed low between edges.
  - Required: outputs clear immediately, and no further we_reg_out after reset is released.
- With WB_COALESCE_EN:
  - Stimulus: stalled; push rd=5 with 8'h01, then rd=5 with 8'h02.
  - Required: count_out=1, and the single drain writes 8'h02.
